// File: rtl/optiune_recorder.sv
// Record/playback sequencer for user option commands: RECORD captures one option per
// rising edge of validare_in, PLAY replays the captured sequence at a fixed tick rate.
module optiune_recorder #(
    parameter int DATA_SIZE = 3,
    parameter int ADDR_SIZE = 4,
    parameter int TICK_MAX  = 500000,
    parameter int TICK_W    = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rec_start,
    input  logic                 play_start,
    input  logic                 stop,
    input  logic [DATA_SIZE-1:0] optiune_in,
    input  logic                 validare_in,
    output logic [DATA_SIZE-1:0] optiune_out,
    output logic                 validare_out,
    output logic                 recording,
    output logic                 playing,
    output logic [ADDR_SIZE:0]   count,
    output logic                 full,
    output logic                 done
);
    localparam int                 DEPTH     = 2**ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] C_DEPTH   = (ADDR_SIZE+1)'(DEPTH);
    localparam logic [ADDR_SIZE:0] C_ONE     = (ADDR_SIZE+1)'(1);
    localparam logic [ADDR_SIZE-1:0] C_PINC  = ADDR_SIZE'(1);
    localparam logic [TICK_W-1:0]  C_TLAST   = TICK_W'(TICK_MAX-1);
    localparam logic [TICK_W-1:0]  C_TINC    = TICK_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_REC, S_PLAY} state_t;

    state_t                 r_state, w_state_nxt;
    logic [ADDR_SIZE:0]     w_count_nxt;
    logic [ADDR_SIZE-1:0]   r_wr_ptr, w_wr_ptr_nxt;
    logic [ADDR_SIZE-1:0]   r_rd_ptr, w_rd_ptr_nxt;
    logic [TICK_W-1:0]      r_tick, w_tick_nxt;
    logic                   r_vin_q;
    logic                   w_cap, w_we, w_emit, w_done_nxt;
    logic [DATA_SIZE-1:0]   r_mem [DEPTH];

    assign w_cap = validare_in & ~r_vin_q;

    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = count;
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_tick_nxt   = r_tick;
        w_we         = 1'b0;
        w_emit       = 1'b0;
        w_done_nxt   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (rec_start) begin
                    w_state_nxt  = S_REC;
                    w_count_nxt  = '0;
                    w_wr_ptr_nxt = '0;
                end else if (play_start) begin
                    if (count != '0) begin
                        w_state_nxt  = S_PLAY;
                        w_rd_ptr_nxt = '0;
                        w_tick_nxt   = '0;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_REC: begin
                // a restart drops any capture arriving in the same cycle
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (rec_start) begin
                    w_count_nxt  = '0;
                    w_wr_ptr_nxt = '0;
                end else if (w_cap) begin
                    w_we         = 1'b1;
                    w_wr_ptr_nxt = r_wr_ptr + C_PINC;
                    w_count_nxt  = count + C_ONE;
                    if (count == C_DEPTH - C_ONE) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (r_tick == C_TLAST) begin
                    w_emit       = 1'b1;
                    w_tick_nxt   = '0;
                    w_rd_ptr_nxt = r_rd_ptr + C_PINC;
                    if ({1'b0, r_rd_ptr} == count - C_ONE) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_tick_nxt = r_tick + C_TINC;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            count        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_tick       <= '0;
            r_vin_q      <= 1'b0;
            optiune_out  <= '0;
            validare_out <= 1'b0;
            done         <= 1'b0;
            recording    <= 1'b0;
            playing      <= 1'b0;
            full         <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            count        <= w_count_nxt;
            r_wr_ptr     <= w_wr_ptr_nxt;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_tick       <= w_tick_nxt;
            r_vin_q      <= validare_in;
            validare_out <= w_emit;
            done         <= w_done_nxt;
            recording    <= (w_state_nxt == S_REC);
            playing      <= (w_state_nxt == S_PLAY);
            full         <= (w_count_nxt == C_DEPTH);
            if (w_emit) optiune_out <= r_mem[r_rd_ptr];
        end
    end

    // buffer storage carries no reset; contents are meaningless until recorded
    always_ff @(posedge clk) begin
        if (w_we) r_mem[r_wr_ptr] <= optiune_in;
    end

endmodule

// File: tb/tb_optiune_recorder.sv
// Randomized self-checking bench for optiune_recorder; the expected sequence is a queue
// of recorded options and replay timing follows directly from the tick period.
module tb_optiune_recorder;
    localparam int DEPTH = 16;
    localparam int TM    = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rec_start = 1'b0, play_start = 1'b0, stop = 1'b0;
    logic [2:0] optiune_in = '0;
    logic       validare_in = 1'b0;
    logic [2:0] optiune_out;
    logic       validare_out, recording, playing, full, done;
    logic [4:0] count;

    int         n_pass = 0;
    int         n_total = 0;
    logic [2:0] m_q[$];
    bit         m_rec = 1'b0;

    optiune_recorder #(.DATA_SIZE(3), .ADDR_SIZE(4), .TICK_MAX(TM), .TICK_W(3)) dut (
        .clk(clk), .rst(rst), .rec_start(rec_start), .play_start(play_start), .stop(stop),
        .optiune_in(optiune_in), .validare_in(validare_in), .optiune_out(optiune_out),
        .validare_out(validare_out), .recording(recording), .playing(playing),
        .count(count), .full(full), .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rec_pulse(input logic [2:0] v, input int hold, input int gap,
                             output logic d_seen, output logic [4:0] c_seen);
        optiune_in  = v;
        validare_in = 1'b1;
        cyc();
        d_seen = done;
        c_seen = count;
        if (m_rec) begin
            m_q.push_back(v);
            if (m_q.size() == DEPTH) m_rec = 1'b0;
        end
        for (int i = 1; i < hold; i++) begin
            optiune_in = 3'($urandom);
            cyc();
        end
        validare_in = 1'b0;
        for (int i = 0; i < gap; i++) cyc();
    endtask

    task automatic do_rec_start();
        rec_start = 1'b1;
        cyc();
        rec_start = 1'b0;
        m_q.delete();
        m_rec = 1'b1;
        n_total++;
        if (recording !== 1'b1 || count !== 5'd0)
            $display("FAIL rec_start: recording=%b count=%0d want 1/0", recording, count);
        else n_pass++;
    endtask

    task automatic record_n(input int n, input bit rnd, input string tag);
        logic d; logic [4:0] c; logic [2:0] v; bit exp_d;
        for (int i = 0; i < n; i++) begin
            v = rnd ? 3'($urandom) : 3'(i % 8);
            exp_d = m_rec && (m_q.size() == DEPTH - 1);
            rec_pulse(v, rnd ? int'($urandom_range(1, 3)) : 3, rnd ? int'($urandom_range(1, 2)) : 1, d, c);
            n_total++;
            if (c !== 5'(m_q.size()) || d !== exp_d)
                $display("FAIL %s_pulse%0d: count=%0d done=%b want %0d/%b", tag, i, c, d, m_q.size(), exp_d);
            else n_pass++;
        end
    endtask

    task automatic do_stop_rec();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        m_rec = 1'b0;
        n_total++;
        if (recording !== 1'b0 || count !== 5'(m_q.size()) || done !== 1'b0)
            $display("FAIL stop_rec: rec=%b count=%0d done=%b want 0/%0d/0", recording, count, done, m_q.size());
        else n_pass++;
    endtask

    task automatic run_play(input int stop_after);
        int n, k, n_done, n_late;
        n = m_q.size(); k = 0; n_done = 0; n_late = 0;
        play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        n_total++;
        if (playing !== 1'b1) $display("FAIL play_enter: playing=%b want 1", playing);
        else n_pass++;
        for (int t = 1; t <= TM * n + 8; t++) begin
            cyc();
            if (done) n_done++;
            if (validare_out) begin
                n_total++;
                if (k >= n || t != TM * (k + 1) || optiune_out !== m_q[k] || done !== (k == n - 1))
                    $display("FAIL strobe%0d: t=%0d val=%0d done=%b want t=%0d val=%0d done=%b",
                             k, t, optiune_out, done, TM * (k + 1), (k < n) ? m_q[k] : 3'd0, (k == n - 1));
                else n_pass++;
                k++;
                if (stop_after != 0 && k == stop_after) break;
            end
        end
        if (stop_after != 0) begin
            stop = 1'b1;
            cyc();
            stop = 1'b0;
            n_total++;
            if (playing !== 1'b0) $display("FAIL stop_play: playing=%b want 0", playing);
            else n_pass++;
            for (int t = 0; t < 3 * TM; t++) begin
                cyc();
                if (validare_out) n_late++;
                if (done) n_done++;
            end
            n_total++;
            if (n_late != 0 || n_done != 0)
                $display("FAIL stop_quiet: strobes=%0d dones=%0d want 0/0", n_late, n_done);
            else n_pass++;
        end else begin
            n_total++;
            if (k != n || n_done != 1 || playing !== 1'b0 || optiune_out !== m_q[n - 1])
                $display("FAIL play_end: strobes=%0d dones=%0d playing=%b out=%0d want %0d/1/0/%0d",
                         k, n_done, playing, optiune_out, n, m_q[n - 1]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        #3;
        n_total++;
        if (optiune_out !== 3'd0 || validare_out !== 1'b0 || recording !== 1'b0 || playing !== 1'b0 ||
            count !== 5'd0 || full !== 1'b0 || done !== 1'b0)
            $display("FAIL reset_outputs: out=%0d v=%b r=%b p=%b c=%0d f=%b d=%b want all 0",
                     optiune_out, validare_out, recording, playing, count, full, done);
        else n_pass++;
        cyc(); cyc();
        rst = 1'b1;
        cyc();
        n_total++;
        if (count !== 5'd0 || done !== 1'b0)
            $display("FAIL post_reset: count=%0d done=%b want 0/0", count, done);
        else n_pass++;
        play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        n_total++;
        if (done !== 1'b1 || playing !== 1'b0)
            $display("FAIL empty_play: done=%b playing=%b want 1/0", done, playing);
        else n_pass++;
        cyc();
        n_total++;
        if (done !== 1'b0) $display("FAIL empty_play_pulse: done=%b want 0", done);
        else n_pass++;
    endtask

    task automatic test_record_basic();
        logic d; logic [4:0] c;
        logic [2:0] vals [3];
        vals[0] = 3'd5; vals[1] = 3'd2; vals[2] = 3'd7;
        do_rec_start();
        for (int i = 0; i < 3; i++) begin
            rec_pulse(vals[i], 3, 1, d, c);
            n_total++;
            if (c !== 5'(i + 1) || d !== 1'b0)
                $display("FAIL basic_pulse%0d: count=%0d done=%b want %0d/0", i, c, d, i + 1);
            else n_pass++;
        end
        do_stop_rec();
    endtask

    task automatic test_fill();
        logic d; logic [4:0] c;
        do_rec_start();
        record_n(DEPTH, 1'b0, "fill");
        n_total++;
        if (full !== 1'b1 || count !== 5'd16 || recording !== 1'b0)
            $display("FAIL fill_state: full=%b count=%0d rec=%b want 1/16/0", full, count, recording);
        else n_pass++;
        rec_pulse(3'd3, 2, 1, d, c);
        n_total++;
        if (c !== 5'd16 || d !== 1'b0)
            $display("FAIL fill_17th: count=%0d done=%b want 16/0", c, d);
        else n_pass++;
    endtask

    task automatic test_reset_mid_play();
        int seen;
        seen = 0;
        play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        for (int t = 0; t < 4 * TM && seen < 2; t++) begin
            cyc();
            if (validare_out) seen++;
        end
        n_total++;
        if (seen != 2 || optiune_out !== 3'd1)
            $display("FAIL pre_reset_play: strobes=%0d out=%0d want 2/1", seen, optiune_out);
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if (optiune_out !== 3'd0 || validare_out !== 1'b0 || playing !== 1'b0 || count !== 5'd0 ||
            full !== 1'b0 || done !== 1'b0)
            $display("FAIL async_reset: out=%0d v=%b p=%b c=%0d f=%b d=%b want all 0",
                     optiune_out, validare_out, playing, count, full, done);
        else n_pass++;
        cyc();
        rst = 1'b1;
        m_q.delete();
        m_rec = 1'b0;
        cyc(); cyc();
        n_total++;
        if (count !== 5'd0 || playing !== 1'b0 || done !== 1'b0)
            $display("FAIL after_reset: count=%0d playing=%b done=%b want 0/0/0", count, playing, done);
        else n_pass++;
    endtask

    task automatic test_priority();
        do_rec_start();
        record_n(2, 1'b1, "prio");
        play_start = 1'b1;
        cyc();
        play_start = 1'b0;
        n_total++;
        if (playing !== 1'b0 || recording !== 1'b1)
            $display("FAIL play_in_rec: playing=%b rec=%b want 0/1", playing, recording);
        else n_pass++;
        stop = 1'b1; rec_start = 1'b1;
        cyc();
        stop = 1'b0; rec_start = 1'b0;
        m_rec = 1'b0;
        n_total++;
        if (recording !== 1'b0 || count !== 5'd2 || done !== 1'b0)
            $display("FAIL stop_vs_rec: rec=%b count=%0d done=%b want 0/2/0", recording, count, done);
        else n_pass++;
    endtask

    task automatic test_restart();
        do_rec_start();
        record_n(3, 1'b1, "pre");
        rec_start = 1'b1; validare_in = 1'b1; optiune_in = 3'd6;
        cyc();
        rec_start = 1'b0;
        m_q.delete();
        n_total++;
        if (count !== 5'd0 || recording !== 1'b1)
            $display("FAIL restart_drop: count=%0d rec=%b want 0/1", count, recording);
        else n_pass++;
        cyc();
        validare_in = 1'b0;
        cyc();
        record_n(2, 1'b1, "post");
        do_stop_rec();
        run_play(0);
    endtask

    initial begin
        test_reset();
        test_record_basic();
        run_play(0);
        test_fill();
        run_play(2);
        run_play(0);
        test_reset_mid_play();
        test_priority();
        test_restart();
        for (int r = 0; r < 3; r++) begin
            do_rec_start();
            record_n(int'($urandom_range(1, 15)), 1'b1, "rnd");
            do_stop_rec();
            run_play(0);
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
